// File: rtl/ysyx_210544_cmt_queue.sv
// Retire queue between writeback and the difftest commit unit; freezes after a trap record.
// Optional same-edge bypass for an empty queue is enabled by defining CMT_QUEUE_BYPASS_EN.
module ysyx_210544_cmt_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [63:0] MMIO_BASE = 64'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wb_valid,
    output logic                       o_wb_ready,
    input  logic [63:0]                i_wb_pc,
    input  logic [31:0]                i_wb_inst,
    input  logic [4:0]                 i_wb_rd,
    input  logic                       i_wb_rd_wen,
    input  logic [63:0]                i_wb_rd_wdata,
    input  logic                       i_wb_memacc,
    input  logic [63:0]                i_wb_memaddr,
    input  logic [31:0]                i_wb_intrNo,
    output logic [4:0]                 o_rd,
    output logic                       o_rd_wen,
    output logic [63:0]                o_rd_wdata,
    output logic [63:0]                o_pc,
    output logic [31:0]                o_inst,
    output logic [31:0]                o_intrNo,
    output logic                       o_cmtvalid,
    output logic                       o_skipcmt,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [63:0] rd_wdata;
        logic [31:0] intr_no;
        logic        skip;
    } rec_t;

    rec_t            mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            halted;
    rec_t            out_q;
    logic            cmtvalid;

    rec_t            in_rec;
    rec_t            out_next;
    logic            push;
    logic            pop;
    logic            bypass;
    logic            store;
    logic            out_load;
    logic            mmio_skip;
    logic            mcycle_skip;

    // MMIO accesses and mcycle CSR reads cannot be replayed by the reference model.
    assign mmio_skip   = i_wb_memacc & (i_wb_memaddr < MMIO_BASE);
    assign mcycle_skip = (i_wb_inst[6:0] == 7'h73) & (i_wb_inst[14:12] != 3'd0)
                       & (i_wb_inst[31:20] == 12'hB00);

    assign in_rec = '{
        pc:       i_wb_pc,
        inst:     i_wb_inst,
        rd:       i_wb_rd,
        rd_wen:   i_wb_rd_wen,
        rd_wdata: i_wb_rd_wdata,
        intr_no:  i_wb_intrNo,
        skip:     mmio_skip | mcycle_skip
    };

    assign o_wb_ready = (count != FULL) & !halted;
    assign push       = i_wb_valid & o_wb_ready;
    assign pop        = (count != '0) & !halted;

`ifdef CMT_QUEUE_BYPASS_EN
    assign bypass = push & (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign store    = push & !bypass;
    assign out_load = pop | bypass;
    assign out_next = bypass ? in_rec : mem[head];

    always_ff @(posedge clk) begin
        if (store) begin
            mem[tail] <= in_rec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store) tail <= tail + AW'(1);
            if (pop)   head <= head + AW'(1);
            case ({store, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q    <= '0;
            cmtvalid <= 1'b0;
            halted   <= 1'b0;
        end else if (out_load) begin
            out_q    <= out_next;
            cmtvalid <= 1'b1;
            if (out_next.inst[6:0] == 7'h6b) halted <= 1'b1;
        end else begin
            cmtvalid <= 1'b0;
        end
    end

    assign o_rd       = out_q.rd;
    assign o_rd_wen   = out_q.rd_wen;
    assign o_rd_wdata = out_q.rd_wdata;
    assign o_pc       = out_q.pc;
    assign o_inst     = out_q.inst;
    assign o_intrNo   = out_q.intr_no;
    assign o_skipcmt  = out_q.skip;
    assign o_cmtvalid = cmtvalid;
    assign o_count    = count;
    assign o_halted   = halted;
endmodule
